// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction-fetch stage that sits between the PC register and decode.
// Each cycle it may issue the current PC to a synchronous instruction
// memory with a 1-cycle read latency. Returned words are tagged with
// their PC and buffered in a small FIFO, which presents them to decode
// over a valid/ready handshake.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   PC          current PC from the PC register
//   pc_advance  PC register enable; high when a fetch is issued this cycle
//   flush       redirect (taken branch); kills the queue and any in-flight fetch
//   imem_addr   instruction memory address (always equal to PC)
//   imem_rdata  memory read data, valid the cycle after imem_addr is sampled
//   instr_valid head entry valid
//   instr_ready decode accepts the head entry
//   instr       head instruction word
//   instr_pc    PC of the head instruction
module fetch_queue #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] PC,
    output logic                     pc_advance,
    input  logic                     flush,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    word;
        logic [ADDRESS_WIDTH-1:0] pc;
    } entry_t;

    entry_t                   mem_q [DEPTH];
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     inflight_q, inflight_d;
    logic [ADDRESS_WIDTH-1:0] inflight_pc_q, inflight_pc_d;

    logic                     issue;
    logic                     push;
    logic                     pop;
    logic [CW:0]              credit_used;

    // An in-flight fetch already owns a slot, so it counts against capacity.
    // This is what lets the push side run without any backpressure.
    assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign issue       = !rst && !flush && (credit_used < (CW+1)'(DEPTH));
    assign push        = inflight_q && !flush && !rst;
    assign pop         = instr_valid && instr_ready;

    assign pc_advance  = issue;
    assign imem_addr   = PC;
    assign instr_valid = (count_q != '0);
    assign instr       = mem_q[rd_ptr_q].word;
    assign instr_pc    = mem_q[rd_ptr_q].pc;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;

        if (flush) begin
            // A pop accepted by decode in this cycle is deliberately ignored:
            // the whole queue is discarded anyway.
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            inflight_d = issue;
            if (issue) begin
                inflight_pc_d = PC;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; all next-state math lives above.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // NOTE: storage has no reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {imem_rdata, inflight_pc_q};
        end
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the program-counter block. Takes the current PC and issues it to a synchronous instruction memory with 1-cycle read latency.
- Buffers the returned instruction words, each tagged with its PC, in a small FIFO. Presents them to decode over a valid/ready handshake.
- Throttles the PC register through pc_advance and discards wrong-path fetches on flush (taken branch).

Parameters:
ADDRESS_WIDTH, 32, width of PC and instruction address
DATA_WIDTH, 32, instruction word width
DEPTH, 4, queue entries; power of two, >= 2

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
PC  input  ADDRESS_WIDTH  current PC from PC register
pc_advance  output  1  PC register enable; PC loads next_PC on edge when pc_advance or flush
flush  input  1  redirect (PCsrc taken); kill queue and in-flight fetch
imem_addr  output  ADDRESS_WIDTH  instruction memory address
imem_rdata  input  DATA_WIDTH  read data, valid 1 cycle after imem_addr sampled
instr_valid  output  1  head entry valid
instr_ready  input  1  decode accepts head
instr  output  DATA_WIDTH  head instruction word
instr_pc  output  ADDRESS_WIDTH  PC of head instruction

Behaviour:
- State: DEPTH-entry storage {instr, pc}, rd_ptr/wr_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH), inflight_q, inflight_pc_q.
- imem_addr = PC, combinational, always driven.
- Issue condition: issue = !rst && !flush && (count + inflight_q < DEPTH). pc_advance = issue. On issue: inflight_q <= 1, inflight_pc_q <= PC; otherwise inflight_q <= 0.
- Push: when inflight_q && !flush, write {imem_rdata, inflight_pc_q} at wr_ptr; wr_ptr++. Push is never blocked; the credit rule guarantees a slot.
- Pop: pop = instr_valid && instr_ready. rd_ptr++ on pop.
- count <= count + push - pop. Simultaneous push and pop leaves count unchanged. A push into an empty queue becomes visible the following cycle; there is no bypass.
- Outputs: instr_valid = (count != 0); instr/instr_pc = entry[rd_ptr]. Consumer values are meaningful only while instr_valid.
- Latency: PC issued at edge N. Data returns during cycle N+1 and is written at edge N+1. instr_valid is high in cycle N+2 at the earliest.
- Throughput: with instr_ready held at 1, one instruction per cycle sustained after fill.
- Flush, highest priority: on the edge where flush=1:
  - count <= 0 and rd_ptr <= wr_ptr.
  - inflight_q <= 0, discarding any response due this cycle.
  - No issue. The PC register loads the branch target.
  - A pop presented in the flush cycle is still accepted by decode, but no state reflects it.
  - instr_valid = 0 in the cycle after flush. The first target instruction appears 2 cycles after the flush cycle's following issue.
- Back-to-back flushes: each cycle with flush=1 repeats the above. No issue occurs until flush deasserts.
- Reset, synchronous and checked before flush: count=0, rd_ptr=wr_ptr=0, inflight_q=0, inflight_pc_q=0. pc_advance=0 while rst=1. Storage contents are not reset.
- Reset mid-operation drops all queued and in-flight instructions. Behaviour after reset is identical to power-up.
- Full: count + inflight_q == DEPTH blocks issue (pc_advance=0), so PC holds. Issue resumes in the cycle after a pop frees credit.
- The PC value is not interpreted (no alignment check). Address arithmetic stays in the PC block.

Test Plan:
1. Release rst at cycle 0, PC increments by 4 from 0x0, instr_ready=1, memory returns word = addr^0xA5A5_0000 -> instr_valid first high cycle 2 with instr_pc=0x0. Then one entry per cycle; instr_pc 0x4, 0x8, ... with matching words; pc_advance constantly 1.
2. DEPTH=4, instr_ready=0 from reset -> exactly 4 issues (PC 0x0..0xC). pc_advance low from cycle 4; count=4; PC holds 0x10. Raise instr_ready -> entries drain in order 0x0..0xC; pc_advance re-asserts the cycle after the first pop.
3. flush asserted while inflight_q=1 and count=2, target 0x100 -> next cycle instr_valid=0, count=0, the in-flight word is never seen. First valid entry has instr_pc=0x100, 3 cycles after the flush cycle.
4. count=3, inflight_q=1, instr_ready=1 (simultaneous push and pop) -> count stays 3, FIFO order preserved across pointer wrap (wr_ptr 3->0).
5. flush and rst together, then flush for 2 consecutive cycles -> reset state each time; pc_advance=0 throughout; no instr_valid until 2 cycles after the first issue.
6. rst pulsed for 1 cycle mid-stream with count=2 -> instr_valid=0 the next cycle, queue empty, refetch resumes from the PC register's reset value.
